// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
// Six-phase sequencer for a two-road intersection: main green / yellow /
// all-red, side green / yellow / all-red. Each phase is timed by one shared
// counter. Main green is held past its minimum until side-road or pedestrian
// demand appears.
//
// Optional feature macro: TRAFFIC_PED_EN (pedestrian request/walk path).
// With it undefined, ped_req is ignored and ped_walk/ped_ack are tied low.
//
// Ports:
//   clk_out      in   divided system clock, rising edge
//   reset        in   synchronous, active-high
//   side_sensor  in   side-road vehicle waiting (level)
//   ped_req      in   pedestrian button (level, sampled every cycle)
//   main_light   out  {red, yellow, green} for the main road, one-hot
//   side_light   out  {red, yellow, green} for the side road, one-hot
//   ped_walk     out  walk signal, high during a side green that serves a request
//   ped_ack      out  one-cycle pulse after a request is latched
//   phase        out  current state encoding (debug)
module traffic_phase_controller #(
  parameter int unsigned CNT_W          = 9,
  parameter int unsigned MAIN_MIN_TICKS = 450,
  parameter int unsigned YELLOW_TICKS   = 75,
  parameter int unsigned ALLRED_TICKS   = 15,
  parameter int unsigned SIDE_TICKS     = 300
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_B  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance_c;
  logic             demand_c;

  // State and phase counter registers
  always_ff @(posedge clk_out) begin
    if (reset) begin
      state_q <= MAIN_G;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    advance_c = 1'b0;
    unique case (state_q)
      MAIN_G: if (cnt_q == MAIN_LAST && demand_c) begin
                advance_c = 1'b1;
                state_d   = MAIN_Y;
              end
      MAIN_Y: if (cnt_q == YELLOW_LAST) begin
                advance_c = 1'b1;
                state_d   = RED_A;
              end
      RED_A:  if (cnt_q == ALLRED_LAST) begin
                advance_c = 1'b1;
                state_d   = SIDE_G;
              end
      SIDE_G: if (cnt_q == SIDE_LAST) begin
                advance_c = 1'b1;
                state_d   = SIDE_Y;
              end
      SIDE_Y: if (cnt_q == YELLOW_LAST) begin
                advance_c = 1'b1;
                state_d   = RED_B;
              end
      RED_B:  if (cnt_q == ALLRED_LAST) begin
                advance_c = 1'b1;
                state_d   = MAIN_G;
              end
      default: begin
                advance_c = 1'b1;
                state_d   = MAIN_G;
              end
    endcase

    // Main green parks at its minimum so demand can be served on any later cycle
    if (advance_c) begin
      cnt_d = '0;
    end else if (state_q == MAIN_G && cnt_q == MAIN_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef TRAFFIC_PED_EN
  logic ped_pending_q;
  logic walk_phase_q;
  logic ped_ack_q;
  logic ped_set_c;
  logic ped_clear_c;

  assign ped_set_c   = ped_req & ~ped_pending_q;
  assign ped_clear_c = (state_q == RED_A) & advance_c;
  assign demand_c    = side_sensor | ped_pending_q;

  // Request latch; the hand-off into side green beats a coincident new request
  always_ff @(posedge clk_out) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
      walk_phase_q  <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      ped_ack_q <= ped_set_c;
      if (ped_clear_c) begin
        walk_phase_q  <= ped_pending_q;
        ped_pending_q <= 1'b0;
      end else if (ped_set_c) begin
        ped_pending_q <= 1'b1;
      end
    end
  end

  assign ped_walk = walk_phase_q & (state_q == SIDE_G);
  assign ped_ack  = ped_ack_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign demand_c       = side_sensor;
  assign ped_walk       = 1'b0;
  assign ped_ack        = 1'b0;
`endif

  // Lamp decode straight from the state register
  always_comb begin
    main_light = 3'b100;
    side_light = 3'b100;
    unique case (state_q)
      MAIN_G:  main_light = 3'b001;
      MAIN_Y:  main_light = 3'b010;
      SIDE_G:  side_light = 3'b001;
      SIDE_Y:  side_light = 3'b010;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios plus random traffic,
// checked against a phase/elapsed-time reference model of the light sequence.
module tb_traffic_phase_controller;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned MAIN_N = 4;
  localparam int unsigned YEL_N  = 2;
  localparam int unsigned RED_N  = 1;
  localparam int unsigned SIDE_N = 3;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk_out = 1'b0;
  logic       reset = 1'b1;
  logic       side_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] phase;

  traffic_phase_controller #(
    .CNT_W(CNT_W), .MAIN_MIN_TICKS(MAIN_N), .YELLOW_TICKS(YEL_N),
    .ALLRED_TICKS(RED_N), .SIDE_TICKS(SIDE_N)
  ) dut (
    .clk_out(clk_out), .reset(reset), .side_sensor(side_sensor), .ped_req(ped_req),
    .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk),
    .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk_out = ~clk_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase index, cycles spent in it, pedestrian bookkeeping
  int unsigned dur [6] = '{MAIN_N, YEL_N, RED_N, SIDE_N, YEL_N, RED_N};
  int m_ph, m_el;
  bit m_pend, m_walk, m_ack;

  function automatic void model_step(input bit r, input bit s, input bit p);
    bit set, dem, leave, clr;
    if (r) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_walk = 0; m_ack = 0;
      return;
    end
    set   = PED_EN && p && !m_pend;
    dem   = s || (PED_EN && m_pend);
    leave = (m_ph == 0) ? (m_el >= int'(MAIN_N) - 1 && dem) : (m_el >= int'(dur[m_ph]) - 1);
    clr   = PED_EN && leave && m_ph == 2;
    if (clr) m_walk = m_pend;
    if (clr) m_pend = 0;
    else if (set) m_pend = 1;
    m_ack = set;
    if (leave) begin
      m_ph = (m_ph + 1) % 6;
      m_el = 0;
    end else begin
      m_el++;
    end
  endfunction

  function automatic logic [2:0] exp_main(input int ph);
    return (ph == 0) ? 3'b001 : (ph == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_side(input int ph);
    return (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
  endfunction

  // Compare the current cycle, then apply inputs for the coming edge
  task automatic cycle(input bit r, input bit s, input bit p);
    check("phase", 32'(phase), 32'(m_ph));
    check("main_light", 32'(main_light), 32'(exp_main(m_ph)));
    check("side_light", 32'(side_light), 32'(exp_side(m_ph)));
    check("ped_walk", 32'(ped_walk), 32'(m_walk && m_ph == 3));
    check("ped_ack", 32'(ped_ack), 32'(m_ack));
    check("main_onehot", 32'($onehot(main_light)), 32'd1);
    check("side_onehot", 32'($onehot(side_light)), 32'd1);
    check("both_nonred", 32'(main_light != 3'b100 && side_light != 3'b100), 32'd0);
    reset = r; side_sensor = s; ped_req = p;
    @(posedge clk_out);
    model_step(r, s, p);
    @(negedge clk_out);
  endtask

  int exp_seq [14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};

  initial begin
    repeat (2) @(posedge clk_out);
    model_step(1'b1, 1'b0, 1'b0);
    @(negedge clk_out);

    // Reset state, then no demand for 50 cycles
    cycle(1, 0, 0);
    for (int k = 0; k < 50; k++) begin
      check("idle_phase", 32'(phase), 32'd0);
      cycle(0, 0, 0);
    end

    // side_sensor held from reset release
    cycle(1, 0, 0);
    for (int k = 0; k < 14; k++) begin
      check("seq_phase", 32'(phase), 32'(exp_seq[k]));
      cycle(0, 1, 0);
    end

    // Late one-cycle demand
    cycle(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) check("late_hold", 32'(phase), 32'd0);
      if (k == 11) check("late_main_y", 32'(phase), 32'd1);
      check("late_walk", 32'(ped_walk), 32'd0);
      cycle(0, k == 10, 0);
    end

    // Pedestrian pulses at cycles 1 and 3
    cycle(1, 0, 0);
    for (int k = 0; k < 14; k++) begin
      check("ped_ack_pulse", 32'(ped_ack), 32'(PED_EN && k == 2));
      check("ped_walk_win", 32'(ped_walk), 32'(PED_EN && k >= 7 && k <= 9));
      cycle(0, 0, k == 1 || k == 3);
    end

    // Reset during SIDE_G with a request pending
    cycle(1, 0, 0);
    for (int k = 0; k < 17; k++) begin
      if (k == 8) check("mid_in_side_g", 32'(phase), 32'd3);
      if (k == 9) begin
        check("mid_rst_phase", 32'(phase), 32'd0);
        check("mid_rst_main", 32'(main_light), 32'b001);
        check("mid_rst_walk", 32'(ped_walk), 32'd0);
      end
      if (k == 15) check("mid_rst_pend_clr", 32'(phase), 32'd0);
      cycle(k == 8, k < 8, k == 7);
    end

    // ped_req held high, no sensor
    cycle(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (!PED_EN) begin
        check("ped_off_phase", 32'(phase), 32'd0);
        check("ped_off_ack", 32'(ped_ack), 32'd0);
        check("ped_off_walk", 32'(ped_walk), 32'd0);
      end
      cycle(0, 0, 1);
    end

    // Random traffic with occasional resets
    for (int k = 0; k < 4000; k++) begin
      cycle(($urandom % 300) == 0, ($urandom % 8) == 0, ($urandom % 12) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Sequencer for the two-road traffic-light intersection. It steps through main-road and side-road green, yellow and all-red phases, and times every phase with an internal programmable counter. It extends main-road green until a side-road vehicle or a pedestrian asks for service. Its light outputs drive the lamp drivers directly, and it runs on the same divided clock as the existing phase timers.

## Interface
Parameters:
- `CNT_W`, 9: phase counter width. Every `*_TICKS` value must be ≤ 2^CNT_W.
- `MAIN_MIN_TICKS`, 450: minimum main-green duration in clk_out cycles (30 s).
- `YELLOW_TICKS`, 75: yellow duration, used for both roads.
- `ALLRED_TICKS`, 15: all-red clearance duration.
- `SIDE_TICKS`, 300: side-green duration (fixed, not extendable).

Ports (one clock; reset is synchronous and active-high):
- `clk_out`, in, 1: divided system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `side_sensor`, in, 1: level; a vehicle is waiting on the side road.
- `ped_req`, in, 1: pedestrian button, treated as a level sampled every cycle.
- `main_light`, out, 3: {red, yellow, green}, one-hot.
- `side_light`, out, 3: {red, yellow, green}, one-hot.
- `ped_walk`, out, 1: walk signal for crossing the main road.
- `ped_ack`, out, 1: one-cycle pulse when a request is latched.
- `phase`, out, 3: current state encoding, for debug and verification.

## Operation
States, with their `phase` encodings:
- MAIN_G = 0
- MAIN_Y = 1
- RED_A = 2
- SIDE_G = 3
- SIDE_Y = 4
- RED_B = 5

Counter behaviour:
- `cnt` clears to 0 on every state transition.
- In every other cycle `cnt` increments.
- In MAIN_G, `cnt` saturates at MAIN_MIN_TICKS-1.

Transitions (`demand` = side_sensor | ped_pending):
- MAIN_G → MAIN_Y when cnt == MAIN_MIN_TICKS-1 and demand. Otherwise MAIN_G holds indefinitely.
- MAIN_Y → RED_A when cnt == YELLOW_TICKS-1.
- RED_A → SIDE_G when cnt == ALLRED_TICKS-1.
- SIDE_G → SIDE_Y when cnt == SIDE_TICKS-1.
- SIDE_Y → RED_B when cnt == YELLOW_TICKS-1.
- RED_B → MAIN_G when cnt == ALLRED_TICKS-1.

Each timed state therefore lasts exactly N cycles.

Light decode (lights are a pure decode of the registered state):
- main_light: MAIN_G = 001, MAIN_Y = 010, every other state = 100.
- side_light: SIDE_G = 001, SIDE_Y = 010, every other state = 100.
- Both roads are never non-red at the same time.

Pedestrian path:
- `ped_pending` sets when ped_req = 1 and ped_pending = 0. `ped_ack` pulses in the following cycle.
- A request that arrives while ped_pending is already set produces no ack.
- On the RED_A → SIDE_G transition, `walk_phase` ← ped_pending and ped_pending ← 0.
- ped_walk = walk_phase & (state == SIDE_G).
- If a set and the clear coincide in the same cycle, the clear wins. A ped_req held high re-sets ped_pending on the next cycle, which yields a new ack.
- A request made during SIDE_G, SIDE_Y or RED_B stays pending and is served in the next cycle of the sequence.

## Timing
- Reset values: state = MAIN_G, cnt = 0, ped_pending = 0, walk_phase = 0.
- Outputs during reset: main_light = 001, side_light = 100, ped_walk = 0, ped_ack = 0, phase = 0.
- Reset asserted mid-sequence returns to MAIN_G on the next edge. All-red clearance is not honoured.
- Cycle 0 is the first edge after reset is released. With demand held, MAIN_Y appears in cycle MAIN_MIN_TICKS and SIDE_G in cycle MAIN_MIN_TICKS+YELLOW_TICKS+ALLRED_TICKS.
- Demand that arrives after the minimum has elapsed causes MAIN_Y one cycle after it is sampled.
- Minimum full cycle length: MAIN_MIN + 2·YELLOW + 2·ALLRED + SIDE_TICKS cycles.
- If side_sensor drops after MAIN_Y has started, the sequence is unaffected. Demand is sampled only in MAIN_G.

## Configuration
- `TRAFFIC_PED_EN` defined: the pedestrian path is present as described above.
- `TRAFFIC_PED_EN` undefined:
  - ped_req is ignored.
  - ped_pending and walk_phase are removed.
  - ped_walk and ped_ack are tied to 0.
  - demand = side_sensor.
  - Port list is unchanged.

## Test plan
Bench parameters: MAIN_MIN = 4, YELLOW = 2, ALLRED = 1, SIDE = 3.
- **Reset, no demand:** run 50 cycles → phase stays 0, main_light = 001, side_light = 100.
- **side_sensor held from reset release:** phase sequence 0×4, 1×2, 2×1, 3×3, 4×2, 5×1, then back to 0. Lights are one-hot and never non-red on both roads.
- **Late demand:** side_sensor pulsed for 1 cycle at cycle 10 → MAIN_Y at cycle 11, and ped_walk stays 0 throughout.
- **Pedestrian request:** ped_req pulsed at cycle 1 → ped_ack = 1 at cycle 2 only. ped_walk = 1 for all 3 SIDE_G cycles. A second pulse at cycle 3 gives no ack.
- **Reset mid-operation:** reset asserted during SIDE_G → next cycle phase = 0, main_light = 001, ped_walk = 0, pending request cleared.
- **Macro off:** with `TRAFFIC_PED_EN` undefined, ped_req held high with no sensor → phase stays 0, and ped_ack and ped_walk stay 0.
